// File: rtl/ssd_hex_driver.sv
// ---------------------------------------------------------------------------
// ssd_hex_driver
//
// Single-digit hexadecimal seven-segment display driver.
// It decodes a 4-bit nibble into the cathode pattern for 0-9, A, b, C, d, E, F.
// It mirrors the nibble onto four LEDs and passes the decimal-point bit through.
// It drives one digit anode on and holds the other seven anodes off.
// Every output is registered, so the latency is one clock.
//
// Parameters
//   CC_ACTIVE_LOW  1: cathodes and dp are active-low.
//                  0: every cathode/dp bit is inverted, except that dp_in
//                     is passed through unmodified.
//   AN_ACTIVE_LOW  1: anodes are active-low.
//                  0: every anode bit is inverted.
//
// Optional build macro
//   SSD_DRIVER_LAMP_TEST_EN  Adds ssd_driver_port_lamp_test. While it is high,
//                            all segments and dp are lit. Reset takes priority.
//
// Ports
//   ssd_driver_port_clk      in   1  clock; all state updates on the rising edge
//   ssd_driver_port_rst      in   1  synchronous active-high reset
//   ssd_driver_port_in       in   4  hex nibble to display
//   ssd_driver_port_dp_in    in   1  decimal-point request, already in output polarity
//   ssd_driver_port_led      out  4  registered copy of the nibble
//   ssd_driver_port_cc       out  7  segment cathodes, bit0=a ... bit6=g
//   ssd_driver_port_dp_out   out  1  decimal-point cathode
//   ssd_driver_port_an_on    out  1  anode of the driven digit
//   ssd_driver_port_an_off   out  7  anodes of the seven unused digits
// ---------------------------------------------------------------------------
module ssd_hex_driver #(
  parameter bit CC_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic       ssd_driver_port_clk,
  input  logic       ssd_driver_port_rst,
  input  logic [3:0] ssd_driver_port_in,
  input  logic       ssd_driver_port_dp_in,
`ifdef SSD_DRIVER_LAMP_TEST_EN
  input  logic       ssd_driver_port_lamp_test,
`endif
  output logic [3:0] ssd_driver_port_led,
  output logic [6:0] ssd_driver_port_cc,
  output logic       ssd_driver_port_dp_out,
  output logic       ssd_driver_port_an_on,
  output logic [6:0] ssd_driver_port_an_off
);

  // The XOR masks turn the internal active-low values into the polarity selected by the parameters.
  localparam logic [6:0] CC_XOR = CC_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic       DP_XOR = CC_ACTIVE_LOW ? 1'b0  : 1'b1;
  localparam logic [6:0] AN_XOR = AN_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic       AN1_XOR = AN_ACTIVE_LOW ? 1'b0 : 1'b1;

  logic [3:0] r_led;
  logic [6:0] r_cc;
  logic       r_dp;
  logic       r_an_on;
  logic [6:0] r_an_off;
  logic       w_lamp;
  logic [6:0] w_seg;

  // Active-low segment pattern, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;  // 4'hF; the case covers all 16 codes
    endcase
    return seg;
  endfunction

`ifdef SSD_DRIVER_LAMP_TEST_EN
  assign w_lamp = ssd_driver_port_lamp_test;
`else
  assign w_lamp = 1'b0;
`endif

  assign w_seg = hex_decode(ssd_driver_port_in);

  // Output register stage
  always_ff @(posedge ssd_driver_port_clk) begin
    if (ssd_driver_port_rst) begin
      r_led    <= 4'h0;
      r_cc     <= 7'h7F ^ CC_XOR;
      r_dp     <= 1'b1 ^ DP_XOR;
      r_an_on  <= 1'b1 ^ AN1_XOR;
      r_an_off <= 7'h7F ^ AN_XOR;
    end else begin
      r_led    <= ssd_driver_port_in;
      r_an_on  <= 1'b0 ^ AN1_XOR;
      r_an_off <= 7'h7F ^ AN_XOR;
      if (w_lamp) begin
        r_cc <= 7'h00 ^ CC_XOR;
        r_dp <= 1'b0 ^ DP_XOR;
      end else begin
        r_cc <= w_seg ^ CC_XOR;
        // dp_in is already in output polarity, so it is passed through unmodified.
        r_dp <= ssd_driver_port_dp_in;
      end
    end
  end

  assign ssd_driver_port_led    = r_led;
  assign ssd_driver_port_cc     = r_cc;
  assign ssd_driver_port_dp_out = r_dp;
  assign ssd_driver_port_an_on  = r_an_on;
  assign ssd_driver_port_an_off = r_an_off;

endmodule

// File: tb/tb_ssd_hex_driver.sv
module tb_ssd_hex_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = 4'h0;
  logic       dp_in = 1'b0;
  logic       lamp = 1'b0;
  logic [3:0] led;
  logic [6:0] cc;
  logic       dp_out;
  logic       an_on;
  logic [6:0] an_off;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ssd_hex_driver dut (
    .ssd_driver_port_clk      (clk),
    .ssd_driver_port_rst      (rst),
    .ssd_driver_port_in       (din),
    .ssd_driver_port_dp_in    (dp_in),
`ifdef SSD_DRIVER_LAMP_TEST_EN
    .ssd_driver_port_lamp_test(lamp),
`endif
    .ssd_driver_port_led      (led),
    .ssd_driver_port_cc       (cc),
    .ssd_driver_port_dp_out   (dp_out),
    .ssd_driver_port_an_on    (an_on),
    .ssd_driver_port_an_off   (an_off)
  );

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic       dp;
    int         cycles;
    logic [3:0] e_led;
    logic [6:0] e_cc;
    logic       e_dp;
    logic       e_an_on;
    logic [6:0] e_an_off;
  } vec_t;

  vec_t vecs[$];

  // Reference model: the lit segments of each glyph, written as segment letters.
  string lit[16];

  function automatic logic [6:0] model_seg(input int d);
    logic [6:0] p;
    string s;
    p = 7'h7F;
    s = lit[d];
    for (int i = 0; i < s.len(); i++) begin
      int idx;
      idx = int'(s[i]) - 97;
      p[idx] = 1'b0;
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_led, input logic [6:0] e_cc,
                           input logic e_dp, input logic e_on, input logic [6:0] e_off);
    check({tag, ".led"},    32'(led),    32'(e_led));
    check({tag, ".cc"},     32'(cc),     32'(e_cc));
    check({tag, ".dp_out"}, 32'(dp_out), 32'(e_dp));
    check({tag, ".an_on"},  32'(an_on),  32'(e_on));
    check({tag, ".an_off"}, 32'(an_off), 32'(e_off));
  endtask

  initial begin
    logic [6:0] tbl [16];
    vec_t v;
    logic p_rst, p_dp, p_lamp;
    logic [3:0] p_in;
    logic [6:0] e_cc;
    logic e_dp;

    lit[0]  = "abcdef";  lit[1]  = "bc";      lit[2]  = "abdeg";  lit[3]  = "abcdg";
    lit[4]  = "bcfg";    lit[5]  = "acdfg";   lit[6]  = "acdefg"; lit[7]  = "abc";
    lit[8]  = "abcdefg"; lit[9]  = "abcdfg";  lit[10] = "abcefg"; lit[11] = "cdefg";
    lit[12] = "adef";    lit[13] = "bcdeg";   lit[14] = "adefg";  lit[15] = "aefg";

    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reset: two cycles with in=8, dp_in=0.
    v = '{rst:1'b1, din:4'h8, dp:1'b0, cycles:2, e_led:4'h0, e_cc:7'h7F, e_dp:1'b1,
          e_an_on:1'b1, e_an_off:7'h7F};
    vecs.push_back(v);
    // Sweep 0..15; each value is held for two clocks, and dp_in toggles starting at 1.
    for (int i = 0; i < 16; i++) begin
      v = '{rst:1'b0, din:4'(i), dp:~i[0], cycles:2, e_led:4'(i), e_cc:tbl[i],
            e_dp:~i[0], e_an_on:1'b0, e_an_off:7'h7F};
      vecs.push_back(v);
    end

    foreach (vecs[k]) begin
      rst = vecs[k].rst; din = vecs[k].din; dp_in = vecs[k].dp;
      for (int c = 0; c < vecs[k].cycles; c++) begin
        tick();
        check_all($sformatf("vec%0d", k), vecs[k].e_led, vecs[k].e_cc, vecs[k].e_dp,
                  vecs[k].e_an_on, vecs[k].e_an_off);
      end
    end

    // Latency: the output must not change between clock edges.
    din = 4'h1; dp_in = 1'b1; tick();
    check("lat.pre", 32'(cc), 32'h79);
    din = 4'h2; #2;
    check("lat.hold", 32'(cc), 32'h79);
    tick();
    check("lat.post", 32'(cc), 32'h24);

    // Back-to-back changes.
    din = 4'h5; tick(); check("b2b.5", 32'(cc), 32'h12);
    din = 4'h6; tick(); check("b2b.6", 32'(cc), 32'h02);
    din = 4'h7; tick(); check("b2b.7", 32'(cc), 32'h78);

    // Mid-run reset.
    din = 4'h9; tick(); check("mrst.run", 32'(cc), 32'h10);
    rst = 1'b1; tick();
    check("mrst.cc", 32'(cc), 32'h7F); check("mrst.an_on", 32'(an_on), 32'h1);
    check("mrst.led", 32'(led), 32'h0);
    rst = 1'b0; tick();
    check("mrst.rel_cc", 32'(cc), 32'h10); check("mrst.rel_an", 32'(an_on), 32'h0);

`ifdef SSD_DRIVER_LAMP_TEST_EN
    din = 4'h1; dp_in = 1'b1; lamp = 1'b1; tick();
    check("lamp.cc", 32'(cc), 32'h00); check("lamp.dp", 32'(dp_out), 32'h0);
    check("lamp.led", 32'(led), 32'h1); check("lamp.an_on", 32'(an_on), 32'h0);
    lamp = 1'b0; tick();
    check("lamp.off_cc", 32'(cc), 32'h79); check("lamp.off_dp", 32'(dp_out), 32'h1);
    lamp = 1'b1; rst = 1'b1; tick();
    check_all("lamp.rst", 4'h0, 7'h7F, 1'b1, 1'b1, 7'h7F);
    rst = 1'b0; lamp = 1'b0;
`endif

    // Randomised run against the segment-letter model.
    for (int i = 0; i < 400; i++) begin
      p_rst  = ($urandom_range(0, 15) == 0);
      p_in   = 4'($urandom_range(0, 15));
      p_dp   = 1'($urandom_range(0, 1));
`ifdef SSD_DRIVER_LAMP_TEST_EN
      p_lamp = ($urandom_range(0, 7) == 0);
`else
      p_lamp = 1'b0;
`endif
      rst = p_rst; din = p_in; dp_in = p_dp; lamp = p_lamp;
      tick();
      if (p_rst) begin
        check_all($sformatf("rnd%0d", i), 4'h0, 7'h7F, 1'b1, 1'b1, 7'h7F);
      end else begin
        e_cc = p_lamp ? 7'h00 : model_seg(int'(p_in));
        e_dp = p_lamp ? 1'b0 : p_dp;
        check_all($sformatf("rnd%0d", i), p_in, e_cc, e_dp, 1'b0, 7'h7F);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
